// File: rtl/stereo_panner_pkg.sv
// Shared encodings, widths and the gain-scaling helper for the stereo panner.
// The aural encodings match those produced by the stereo MCU.
package stereo_panner_pkg;

    localparam int SAMPLE_W = 16;
    localparam int GAIN_W   = 4;
    localparam int GAIN_MAX = 1 << GAIN_W;
    localparam int PROD_W   = SAMPLE_W + GAIN_W + 1;

    // bit1 = left on, bit0 = right on
    typedef enum logic [1:0] {
        AURAL_MUTE  = 2'b00,
        AURAL_RIGHT = 2'b01,
        AURAL_LEFT  = 2'b10,
        AURAL_BOTH  = 2'b11
    } aural_e;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic        [GAIN_W:0]     gain_t;

    // sample * gain / GAIN_MAX with floor rounding. Gain never exceeds unity,
    // so the truncated result always fits (including -32768 at unity).
    function automatic sample_t scale(input sample_t s, input gain_t g);
        logic signed [PROD_W-1:0] p;
        p = PROD_W'(s) * $signed(PROD_W'(g));
        return SAMPLE_W'(p >>> GAIN_W);
    endfunction

endpackage

// File: rtl/stereo_panner_if.sv
// Sample/aural bus between the MCU side (master) and the panner (slave).
interface stereo_panner_if;
    import stereo_panner_pkg::*;

    aural_e  aural_state;
    sample_t sample_in;
    logic    sample_valid;
    sample_t left_out;
    sample_t right_out;
    logic    out_valid;
    logic    ramp_busy;

    modport master (
        output aural_state, sample_in, sample_valid,
        input  left_out, right_out, out_valid, ramp_busy
    );

    modport slave (
        input  aural_state, sample_in, sample_valid,
        output left_out, right_out, out_valid, ramp_busy
    );

endinterface

// File: rtl/stereo_panner_gain_ramp.sv
// Per-channel gain register that walks one step toward 0 or unity on each
// accepted sample. Ramp rate is counted in samples, not clocks.
module gain_ramp #(
    parameter int GAIN_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            step_en,
    input  logic            target_on,
    output logic [GAIN_W:0] gain,
    output logic            busy
);

    localparam logic [GAIN_W:0] GAIN_MAX = {1'b1, {GAIN_W{1'b0}}};
    localparam logic [GAIN_W:0] ONE      = (GAIN_W+1)'(1);

    logic [GAIN_W:0] gain_q, gain_d;
    logic [GAIN_W:0] tgt;

    assign tgt  = target_on ? GAIN_MAX : '0;
    assign busy = (gain_q != tgt);
    assign gain = gain_q;

    // Step toward target; the target itself is the bound, so no wrap is possible.
    always_comb begin
        gain_d = gain_q;
        if (step_en) begin
            if (gain_q < tgt)      gain_d = gain_q + ONE;
            else if (gain_q > tgt) gain_d = gain_q - ONE;
        end
    end

    // Gain register, unity out of reset.
    always_ff @(posedge clk) begin
        if (rst) gain_q <= GAIN_MAX;
        else     gain_q <= gain_d;
    end

endmodule

// File: rtl/stereo_panner.sv
// Mono-to-stereo panner: stage 1 captures the sample with the pre-step gains,
// stage 2 scales both channels and registers the outputs.
module stereo_panner
    import stereo_panner_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    stereo_panner_if.slave    bus
);

    logic [1:0] aural;
    gain_t      gain_l, gain_r;
    logic       busy_l, busy_r;

    assign aural = bus.aural_state;

    gain_ramp #(.GAIN_W(GAIN_W)) u_ramp_l (
        .clk       (clk),
        .rst       (rst),
        .step_en   (bus.sample_valid),
        .target_on (aural[1]),
        .gain      (gain_l),
        .busy      (busy_l)
    );

    gain_ramp #(.GAIN_W(GAIN_W)) u_ramp_r (
        .clk       (clk),
        .rst       (rst),
        .step_en   (bus.sample_valid),
        .target_on (aural[0]),
        .gain      (gain_r),
        .busy      (busy_r)
    );

    // vld_pipe[1]: stage-1 holds a sample; vld_pipe[2]: outputs updated this cycle
    logic [2:1] vld_pipe_q, vld_pipe_d;
    sample_t    s1_sample_q, s1_sample_d;
    gain_t      s1_gain_l_q, s1_gain_l_d;
    gain_t      s1_gain_r_q, s1_gain_r_d;
    sample_t    left_q, left_d;
    sample_t    right_q, right_d;

    // Next-state for both pipeline stages; data registers hold when idle.
    always_comb begin
        vld_pipe_d  = {vld_pipe_q[1], bus.sample_valid};
        s1_sample_d = s1_sample_q;
        s1_gain_l_d = s1_gain_l_q;
        s1_gain_r_d = s1_gain_r_q;
        left_d      = left_q;
        right_d     = right_q;
        if (bus.sample_valid) begin
            s1_sample_d = bus.sample_in;
            s1_gain_l_d = gain_l;
            s1_gain_r_d = gain_r;
        end
        if (vld_pipe_q[1]) begin
            left_d  = scale(s1_sample_q, s1_gain_l_q);
            right_d = scale(s1_sample_q, s1_gain_r_q);
        end
    end

    // Pipeline registers; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q  <= '0;
            s1_sample_q <= '0;
            s1_gain_l_q <= '0;
            s1_gain_r_q <= '0;
            left_q      <= '0;
            right_q     <= '0;
        end else begin
            vld_pipe_q  <= vld_pipe_d;
            s1_sample_q <= s1_sample_d;
            s1_gain_l_q <= s1_gain_l_d;
            s1_gain_r_q <= s1_gain_r_d;
            left_q      <= left_d;
            right_q     <= right_d;
        end
    end

    assign bus.left_out  = left_q;
    assign bus.right_out = right_q;
    assign bus.out_valid = vld_pipe_q[2];
    assign bus.ramp_busy = busy_l | busy_r;

endmodule

// File: tb/tb_stereo_panner.sv
// Scoreboard bench for stereo_panner: stimulus pushes expected outputs from a
// gain-per-channel reference model; a negedge monitor pops and compares.
module tb_stereo_panner;
    import stereo_panner_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stereo_panner_if bus();

    stereo_panner dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int l;
        int r;
        int due;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   ncyc   = 0;
    int   gl     = GAIN_MAX;
    int   gr     = GAIN_MAX;
    int   last_l = 0;
    int   last_r = 0;

    // Reference: output = floor(sample * gain / 16)
    function automatic int ref_scale(int s, int g);
        int p;
        p = s * g;
        if (p >= 0) return p / GAIN_MAX;
        return -((-p + GAIN_MAX - 1) / GAIN_MAX);
    endfunction

    function automatic int ref_step(int g, bit on);
        int t;
        t = on ? GAIN_MAX : 0;
        if (g < t) return g + 1;
        if (g > t) return g - 1;
        return g;
    endfunction

    function automatic bit ref_busy();
        logic [1:0] a;
        a = bus.aural_state;
        return (gl != (a[1] ? GAIN_MAX : 0)) || (gr != (a[0] ? GAIN_MAX : 0));
    endfunction

    task automatic check(string name, logic signed [31:0] act, logic signed [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pop on out_valid, check hold/latency/busy otherwise.
    always @(negedge clk) begin
        exp_t e;
        ncyc++;
        if (!rst) begin
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("out_cycle", ncyc, e.due);
                    check("left_out", bus.left_out, e.l);
                    check("right_out", bus.right_out, e.r);
                    last_l = e.l;
                    last_r = e.r;
                end
            end else begin
                check("left_hold", bus.left_out, last_l);
                check("right_hold", bus.right_out, last_r);
                if (sb.size() > 0 && ncyc > sb[0].due) begin
                    check("out_valid_missing", 0, 1);
                    void'(sb.pop_front());
                end
            end
            check("ramp_busy", bus.ramp_busy, ref_busy());
        end
    end

    // Drive one sample in the current cycle; the model steps gains on acceptance.
    task automatic send(int s);
        logic [1:0] a;
        bus.sample_in    = sample_t'(s);
        bus.sample_valid = 1'b1;
        sb.push_back('{ref_scale(s, gl), ref_scale(s, gr), ncyc + 3});
        @(posedge clk);
        a  = bus.aural_state;
        gl = ref_step(gl, a[1]);
        gr = ref_step(gr, a[0]);
        #1 bus.sample_valid = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.sample_valid = 1'b0;
        idle(2);
        sb.delete();
        gl = GAIN_MAX;
        gr = GAIN_MAX;
        last_l = 0;
        last_r = 0;
        rst = 1'b0;
    endtask

    function automatic int rand_sample();
        logic signed [15:0] r;
        r = 16'($urandom);
        return int'(r);
    endfunction

    initial begin
        bus.aural_state  = AURAL_BOTH;
        bus.sample_in    = '0;
        bus.sample_valid = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // 1: reset state, unity passthrough
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_left", bus.left_out, 0);
        check("rst_right", bus.right_out, 0);
        check("rst_busy", bus.ramp_busy, 0);
        send(1000);
        idle(3);
        check("t1_left", bus.left_out, 1000);
        check("t1_right", bus.right_out, 1000);

        // 2: right fade-out over 16 samples
        bus.aural_state = AURAL_LEFT;
        #1 check("t2_busy_start", bus.ramp_busy, 1);
        for (int i = 0; i < 16; i++) send(1600);
        check("t2_busy_done", bus.ramp_busy, 0);
        idle(3);
        check("t2_right_last", bus.right_out, 100);
        send(1600);
        idle(3);
        check("t2_right_zero", bus.right_out, 0);
        check("t2_left", bus.left_out, 1600);

        // 3: half fade-in of right, then swap to right-only mid-ramp
        bus.aural_state = AURAL_BOTH;
        for (int i = 0; i < 8; i++) send(16000);
        bus.aural_state = AURAL_RIGHT;
        for (int i = 0; i < 18; i++) send(16000 - i * 100);
        check("t3_busy_done", bus.ramp_busy, 0);

        // 4: full scale negative at unity, back-to-back
        bus.aural_state = AURAL_BOTH;
        for (int i = 0; i < 16; i++) send(rand_sample());
        for (int i = 0; i < 20; i++) send(-32768);
        idle(3);
        check("t4_left", bus.left_out, -32768);
        check("t4_right", bus.right_out, -32768);

        // 5: reset one cycle after a sample is accepted
        bus.aural_state = AURAL_LEFT;
        for (int i = 0; i < 5; i++) send(2000);
        idle(3);
        send(1234);
        do_reset();
        idle(4);
        check("t5_left", bus.left_out, 0);
        check("t5_right", bus.right_out, 0);
        check("t5_busy_left_only", bus.ramp_busy, 1);
        bus.aural_state = AURAL_BOTH;
        #1 check("t5_gains_unity", bus.ramp_busy, 0);

        // 6: aural toggling with no samples leaves gains alone
        for (int i = 0; i < 100; i++) begin
            bus.aural_state = (i % 2) ? AURAL_RIGHT : AURAL_LEFT;
            idle(1);
        end
        bus.aural_state = AURAL_BOTH;
        #1 check("t6_gains_unchanged", bus.ramp_busy, 0);

        // Random phase
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) bus.aural_state = aural_e'($urandom_range(0, 3));
            if ($urandom_range(0, 2) != 0) send(rand_sample());
            else idle(1);
        end

        idle(6);
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
